// File: rtl/sad_search_sched_if.sv
// Engine-side bus of the SAD search scheduler: candidate issue and result return.
interface sad_search_sched_if #(
   parameter int MV_W  = 5,
   parameter int SAD_W = 32
);
   logic                   sad_start;
   logic signed [MV_W-1:0] cand_dx;
   logic signed [MV_W-1:0] cand_dy;
   logic                   sad_done;
   logic [SAD_W-1:0]       sad_val;

   modport master (
      output sad_start, cand_dx, cand_dy,
      input  sad_done, sad_val
   );

   modport slave (
      input  sad_start, cand_dx, cand_dy,
      output sad_done, sad_val
   );
endinterface

// File: rtl/sad_search_sched.sv
// Full-search motion-estimation scheduler: walks the +/-RANGE window in raster
// order, issues one SAD per candidate and keeps the minimum and its vector.
module sad_search_sched #(
   parameter int RANGE = 4,
   parameter int MV_W  = 5,
   parameter int SAD_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   srch_start,
   input  logic                   abort,
   sad_search_sched_if.master     eng,
   output logic                   busy,
   output logic                   srch_done,
   output logic [SAD_W-1:0]       best_sad,
   output logic signed [MV_W-1:0] best_dx,
   output logic signed [MV_W-1:0] best_dy,
   output logic [7:0]             cand_idx
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CMP, DONE} state_t;

   localparam logic signed [MV_W-1:0] POS = MV_W'(RANGE);
   localparam logic signed [MV_W-1:0] NEG = -POS;

   state_t st;
   state_t nxt;

   logic signed [MV_W-1:0] dx;
   logic signed [MV_W-1:0] dy;
   logic signed [MV_W-1:0] min_dx;
   logic signed [MV_W-1:0] min_dy;
   logic [SAD_W-1:0]       lat;
   logic [SAD_W-1:0]       min_sad;

   logic                   last;
   logic                   upd;
   logic [SAD_W-1:0]       nmin;
   logic signed [MV_W-1:0] nmin_dx;
   logic signed [MV_W-1:0] nmin_dy;

   // Strict compare: ties keep the earlier raster candidate.
   assign last    = (dx == POS) && (dy == POS);
   assign upd     = lat < min_sad;
   assign nmin    = upd ? lat : min_sad;
   assign nmin_dx = upd ? dx : min_dx;
   assign nmin_dy = upd ? dy : min_dy;

   assign eng.cand_dx = dx;
   assign eng.cand_dy = dy;

   always_ff @(posedge clk) begin
      if (rst) st <= IDLE;
      else     st <= nxt;
   end

   always_comb begin
      nxt           = st;
      eng.sad_start = 1'b0;
      busy          = 1'b1;
      srch_done     = 1'b0;
      unique case (st)
         IDLE: begin
            busy = 1'b0;
            if (srch_start) nxt = ISSUE;
         end
         ISSUE: begin
            eng.sad_start = 1'b1;
            nxt = abort ? IDLE : WAIT;
         end
         WAIT: begin
            if (abort)             nxt = IDLE;
            else if (eng.sad_done) nxt = CMP;
         end
         CMP: begin
            if (abort)     nxt = IDLE;
            else if (last) nxt = DONE;
            else           nxt = ISSUE;
         end
         DONE: begin
            srch_done = 1'b1;
            nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dx       <= '0;
         dy       <= '0;
         min_dx   <= '0;
         min_dy   <= '0;
         lat      <= '0;
         min_sad  <= '1;
         best_sad <= '1;
         best_dx  <= '0;
         best_dy  <= '0;
         cand_idx <= '0;
      end else begin
         if (st == IDLE && srch_start) begin
            dx       <= NEG;
            dy       <= NEG;
            min_dx   <= NEG;
            min_dy   <= NEG;
            min_sad  <= '1;
            cand_idx <= '0;
         end
         if (st == WAIT && !abort && eng.sad_done)
            lat <= eng.sad_val;
         if (st == CMP && !abort) begin
            min_sad  <= nmin;
            min_dx   <= nmin_dx;
            min_dy   <= nmin_dy;
            cand_idx <= cand_idx + 8'd1;
            if (dx != POS) begin
               dx <= dx + 1'b1;
            end else if (dy != POS) begin
               dx <= NEG;
               dy <= dy + 1'b1;
            end
            // Results are published on entry to DONE so they are valid with srch_done.
            if (last) begin
               best_sad <= nmin;
               best_dx  <= nmin_dx;
               best_dy  <= nmin_dy;
            end
         end
      end
   end
endmodule
